// File: rtl/note_step_sequencer.sv
// Sample-rate prescaler plus a 16-step pattern sequencer driving note index and gate
// for the voice synth. The sequencer only moves on sample ticks.
module note_step_sequencer #(
    parameter  int SAMPLE_DIV = 21,
    parameter  int NUM_STEPS  = 16,
    parameter  int STEP_W     = 12,
    localparam int IDX_W      = $clog2(NUM_STEPS),
    localparam int PS_W       = $clog2(SAMPLE_DIV)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [STEP_W-1:0] step_len,
    input  logic [STEP_W-1:0] gate_len,
    input  logic [IDX_W-1:0]  loop_last,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [4:0]        wr_data,
    output logic              sample_tick,
    output logic              step_pulse,
    output logic [IDX_W-1:0]  step_idx,
    output logic [3:0]        note_out,
    output logic              gate_out
);

    // state   | meaning
    // IDLE    | stopped, waiting for a tick with run=1
    // GATE    | step playing, gate high
    // HOLD    | step playing, gate low until step end
    // Loading a step is an action taken on the tick that leaves IDLE or ends HOLD.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GATE = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [PS_W-1:0]   ps_q, ps_d;
    logic              tick_q, tick_d;
    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] tcnt_q, tcnt_d;
    logic [IDX_W-1:0]  step_idx_q, step_idx_d;
    logic [3:0]        note_q, note_d;
    logic              gate_q, gate_d;
    logic              pulse_q, pulse_d;
    logic [4:0]        pat_q [NUM_STEPS];
    logic [4:0]        pat_d [NUM_STEPS];

    logic [STEP_W-1:0] eff_step, eff_gate, step_m1, tcnt_inc;
    logic [IDX_W-1:0]  next_idx, load_idx;
    logic              load_en;

    always_comb begin
        ps_d   = (ps_q == PS_W'(SAMPLE_DIV - 1)) ? '0 : ps_q + 1'b1;
        tick_d = (ps_q == PS_W'(SAMPLE_DIV - 1));
    end

    // Gate is clamped so every step ends with at least one low tick for retrigger.
    always_comb begin
        eff_step = (step_len < STEP_W'(2)) ? STEP_W'(2) : step_len;
        step_m1  = eff_step - 1'b1;
        eff_gate = (gate_len > step_m1) ? step_m1 : gate_len;
        tcnt_inc = tcnt_q + 1'b1;
        next_idx = (step_idx_q >= loop_last) ? '0 : step_idx_q + 1'b1;
    end

    always_comb begin
        pat_d = pat_q;
        if (wr_en) begin
            pat_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        step_idx_d = step_idx_q;
        note_d     = note_q;
        gate_d     = gate_q;
        pulse_d    = 1'b0;
        load_en    = 1'b0;
        load_idx   = '0;

        if (tick_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        load_en  = 1'b1;
                        load_idx = '0;
                    end
                end
                ST_GATE: begin
                    if (!run) begin
                        gate_d     = 1'b0;
                        step_idx_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_inc;
                        if (tcnt_inc >= eff_gate) begin
                            gate_d  = 1'b0;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!run) begin
                        gate_d     = 1'b0;
                        step_idx_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_inc;
                        if (tcnt_inc >= eff_step) begin
                            load_en  = 1'b1;
                            load_idx = next_idx;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Reads the pre-write pattern so a same-cycle write lands on the next loop.
        if (load_en) begin
            step_idx_d = load_idx;
            note_d     = pat_q[load_idx][3:0];
            gate_d     = ~pat_q[load_idx][4] & (eff_gate != '0);
            tcnt_d     = '0;
            pulse_d    = 1'b1;
            state_d    = gate_d ? ST_GATE : ST_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_q       <= '0;
            tick_q     <= 1'b0;
            state_q    <= ST_IDLE;
            tcnt_q     <= '0;
            step_idx_q <= '0;
            note_q     <= '0;
            gate_q     <= 1'b0;
            pulse_q    <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                pat_q[i] <= '0;
            end
        end else begin
            ps_q       <= ps_d;
            tick_q     <= tick_d;
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            step_idx_q <= step_idx_d;
            note_q     <= note_d;
            gate_q     <= gate_d;
            pulse_q    <= pulse_d;
            pat_q      <= pat_d;
        end
    end

    assign sample_tick = tick_q;
    assign step_pulse  = pulse_q;
    assign step_idx    = step_idx_q;
    assign note_out    = note_q;
    assign gate_out    = gate_q;

endmodule
